// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I-subset core: sequences the shared ALU
// and drives every datapath enable, mux select and the ALU operation.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALU_control,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state;
    logic       pcupdate;
    logic       branch;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_R:         state <= EXECR;
                        OP_I:         state <= EXECI;
                        OP_BEQ:       state <= BEQ;
                        OP_JAL:       state <= JAL;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                JAL:      state <= ALUWB;
                default:  state <= FETCH;
            endcase
        end
    end

    // While reset is held the selects mirror FETCH but every enable stays low.
    always_comb begin
        pcupdate   = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        if (!rst_n) begin
            ResultSrc = 2'b10;
            ALUSrcB   = 2'b10;
        end else begin
            case (state)
                FETCH: begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    pcupdate  = 1'b1;
                end
                DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    case (op)
                        OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_op = 1'b0;
                        default:                                  illegal_op = 1'b1;
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                MEMREAD: begin
                    AdrSrc = 1'b1;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                EXECR: begin
                    ALUSrcA = 2'b10;
                    aluop   = 2'b10;
                end
                EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    aluop   = 2'b10;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                end
                BEQ: begin
                    ALUSrcA = 2'b10;
                    aluop   = 2'b01;
                    branch  = 1'b1;
                end
                JAL: begin
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    pcupdate = 1'b1;
                end
                default: begin
                    pcupdate = 1'b0;
                end
            endcase
        end
    end

    assign PCWrite = pcupdate | (branch & zero);

    always_comb begin
        case (aluop)
            2'b01: ALU_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALU_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALU_control = 3'b101;
                    3'b110:  ALU_control = 3'b011;
                    3'b111:  ALU_control = 3'b010;
                    default: ALU_control = 3'b000;
                endcase
            end
            default: ALU_control = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams checked
// cycle by cycle against a per-instruction step model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALU_control;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALU_control(ALU_control), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // kinds: 0 lw, 1 sw, 2 R, 3 I-ALU, 4 beq, 5 jal, 6 illegal
    function automatic logic [6:0] kind_op(input int kind);
        case (kind)
            0: return 7'b0000011;
            1: return 7'b0100011;
            2: return 7'b0110011;
            3: return 7'b0010011;
            4: return 7'b1100011;
            5: return 7'b1101111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int kind_len(input int kind);
        int lens[7] = '{5, 4, 4, 4, 3, 4, 2};
        return lens[kind];
    endfunction

    function automatic logic [1:0] kind_imm(input int kind);
        case (kind)
            1: return 2'b01;
            4: return 2'b10;
            5: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALU_control,illegal_op}
    function automatic logic [14:0] model(input int kind, input int step,
                                          input logic [2:0] f3, input logic f7, input logic z);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] res = 0, a = 0, b = 0;
        logic [2:0] alu = 0;
        if (step == 0) begin
            pcw = 1; irw = 1; res = 2; b = 2;
        end else if (step == 1) begin
            a = 1; b = 1; ill = (kind == 6);
        end else begin
            case (kind)
                0: if (step == 2) begin a = 2; b = 1; end
                   else if (step == 3) adr = 1;
                   else begin res = 1; rw = 1; end
                1: if (step == 2) begin a = 2; b = 1; end
                   else begin adr = 1; mw = 1; end
                2, 3: if (step == 2) begin
                       a = 2; b = (kind == 3) ? 2'd1 : 2'd0;
                       alu = alu_dec(f3, (kind == 2) && f7);
                   end else rw = 1;
                4: begin a = 2; alu = 1; pcw = z; end
                5: if (step == 2) begin a = 1; b = 2; pcw = 1; end
                   else rw = 1;
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rw, res, a, b, alu, ill};
    endfunction

    function automatic logic [14:0] observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALU_control, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(input int kind, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic force_z, input logic zval);
        op = o; funct3 = f3; funct7b5 = f7;
        for (int s = 0; s < kind_len(kind); s++) begin
            zero = force_z ? zval : 1'($urandom);
            #1;
            chk($sformatf("k%0d op%b f3%b step%0d", kind, o, f3, s), observed(),
                model(kind, s, f3, f7, zero));
            chk($sformatf("imm k%0d step%0d", kind, s), {13'd0, ImmSrc}, {13'd0, kind_imm(kind)});
            @(negedge clk);
        end
    endtask

    function automatic logic legal(input logic [6:0] o);
        for (int k = 0; k < 6; k++) if (o == kind_op(k)) return 1'b1;
        return 1'b0;
    endfunction

    localparam logic [14:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};

    initial begin
        rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1 chk("reset_hold", observed(), RST_VEC);
            @(negedge clk);
        end
        rst_n = 1'b1;

        run_instr(0, kind_op(0), 3'b010, 1'b0, 1'b0, 1'b0);
        run_instr(2, kind_op(2), 3'b000, 1'b1, 1'b0, 1'b0);
        run_instr(2, kind_op(2), 3'b110, 1'b0, 1'b0, 1'b0);
        run_instr(2, kind_op(2), 3'b111, 1'b0, 1'b0, 1'b0);
        run_instr(2, kind_op(2), 3'b010, 1'b0, 1'b0, 1'b0);
        run_instr(3, kind_op(3), 3'b000, 1'b1, 1'b0, 1'b0);
        run_instr(1, kind_op(1), 3'b010, 1'b0, 1'b0, 1'b0);
        run_instr(4, kind_op(4), 3'b000, 1'b0, 1'b1, 1'b1);
        run_instr(4, kind_op(4), 3'b000, 1'b0, 1'b1, 1'b0);
        run_instr(5, kind_op(5), 3'b000, 1'b0, 1'b0, 1'b0);
        run_instr(6, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            int k;
            logic [6:0] o;
            k = int'($urandom_range(0, 6));
            o = kind_op(k);
            if (k == 6) begin
                o = 7'($urandom);
                while (legal(o)) o = 7'($urandom);
            end
            run_instr(k, o, 3'($urandom), 1'($urandom), 1'b0, 1'b0);
        end

        // Abandon an R-type in EXECR by holding reset for three edges.
        op = kind_op(2); funct3 = 3'b000; funct7b5 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            zero = 1'($urandom);
            #1 chk($sformatf("reset_execr_%0d", i), observed(), RST_VEC);
            @(negedge clk);
        end
        rst_n = 1'b1;
        run_instr(5, kind_op(5), 3'b000, 1'b0, 1'b0, 1'b0);
        run_instr(0, kind_op(0), 3'b000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
